// File: rtl/mux_share_arbiter.sv
// Round-robin arbiter sharing one select-and-compute datapath between two
// valid/ready requesters, with a one-deep registered output buffer.
module mux_share_arbiter #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SHIFT = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in0_valid,
    input  logic [WIDTH-1:0] in0_data,
    output logic             in0_ready,
    input  logic             in1_valid,
    input  logic [WIDTH-1:0] in1_data,
    output logic             in1_ready,
    output logic             sel,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_src,
    input  logic             out_ready
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           r_state;
    logic             r_last_grant;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_src;

    logic             w_can_accept;
    logic             w_any_valid;
    logic             w_grant;
    logic             w_xfer;
    logic [WIDTH-1:0] w_shifted;
    logic [WIDTH-1:0] w_mux;

    // A full buffer can refill in the same cycle it is drained.
    assign w_can_accept = (r_state == EMPTY) || out_ready;
    assign w_any_valid  = in0_valid || in1_valid;

    // Contention goes to the requester that did not win last time.
    always_comb begin
        w_grant = r_last_grant;
        if (in0_valid && in1_valid) begin
            w_grant = ~r_last_grant;
        end else if (in0_valid) begin
            w_grant = 1'b0;
        end else if (in1_valid) begin
            w_grant = 1'b1;
        end
    end

    // Shift amounts at or beyond WIDTH clear the operand entirely.
    assign w_shifted = (SHIFT >= WIDTH) ? '0 : WIDTH'(in0_data << SHIFT);
    assign w_mux     = w_grant ? in1_data : w_shifted;

    assign w_xfer    = w_any_valid && w_can_accept;
    assign sel       = w_grant;
    assign in0_ready = w_xfer && !w_grant;
    assign in1_ready = w_xfer && w_grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= EMPTY;
            r_last_grant <= 1'b1;
            r_out_data   <= '0;
            r_out_src    <= 1'b0;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_xfer) begin
                        r_state      <= FULL;
                        r_out_data   <= w_mux;
                        r_out_src    <= w_grant;
                        r_last_grant <= w_grant;
                    end
                end
                FULL: begin
                    if (w_xfer) begin
                        r_out_data   <= w_mux;
                        r_out_src    <= w_grant;
                        r_last_grant <= w_grant;
                    end else if (out_ready) begin
                        r_state <= EMPTY;
                    end
                end
                default: r_state <= EMPTY;
            endcase
        end
    end

    assign out_valid = (r_state == FULL);
    assign out_data  = r_out_data;
    assign out_src   = r_out_src;

endmodule

// File: tb/tb_mux_share_arbiter.sv
// Directed, table-driven bench for mux_share_arbiter (WIDTH=8, SHIFT=3).
module tb_mux_share_arbiter;

    logic       clk;
    logic       rst_n;
    logic       in0_valid;
    logic [7:0] in0_data;
    logic       in0_ready;
    logic       in1_valid;
    logic [7:0] in1_data;
    logic       in1_ready;
    logic       sel;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_src;
    logic       out_ready;

    int n_tests;
    int n_fail;

    mux_share_arbiter #(.WIDTH(8), .SHIFT(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in0_valid (in0_valid),
        .in0_data  (in0_data),
        .in0_ready (in0_ready),
        .in1_valid (in1_valid),
        .in1_data  (in1_data),
        .in1_ready (in1_ready),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v0;
        logic [7:0] d0;
        logic       v1;
        logic [7:0] d1;
        logic       ordy;
        logic       e_rdy0;
        logic       e_rdy1;
        logic       e_sel;
        logic       e_ov;
        logic [7:0] e_od;
        logic       e_src;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v0, input logic [7:0] d0, input logic v1,
                         input logic [7:0] d1, input logic ordy);
        in0_valid = v0;
        in0_data  = d0;
        in1_valid = v1;
        in1_data  = d1;
        out_ready = ordy;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_src", 32'(out_src), 32'd0);
        chk("rst_in0_ready", 32'(in0_ready), 32'd0);
        chk("rst_in1_ready", 32'(in1_ready), 32'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);

        //          v0  d0     v1  d1     ordy  rdy0 rdy1 sel  ov   od     src
        vecs[0]  = '{1, 8'h05, 0, 8'h00, 1,    1,   0,   0,   1,   8'h28, 0};
        vecs[1]  = '{1, 8'h30, 0, 8'h00, 1,    1,   0,   0,   1,   8'h80, 0};
        vecs[2]  = '{0, 8'h00, 1, 8'hA5, 1,    0,   1,   1,   1,   8'hA5, 1};
        vecs[3]  = '{1, 8'h01, 1, 8'h02, 1,    1,   0,   0,   1,   8'h08, 0};
        vecs[4]  = '{1, 8'h03, 1, 8'h04, 1,    0,   1,   1,   1,   8'h04, 1};
        vecs[5]  = '{1, 8'h05, 1, 8'h06, 1,    1,   0,   0,   1,   8'h28, 0};
        vecs[6]  = '{1, 8'h07, 1, 8'h08, 1,    0,   1,   1,   1,   8'h08, 1};
        vecs[7]  = '{1, 8'h09, 1, 8'h0A, 1,    1,   0,   0,   1,   8'h48, 0};
        vecs[8]  = '{1, 8'h0B, 1, 8'h0C, 1,    0,   1,   1,   1,   8'h0C, 1};
        vecs[9]  = '{0, 8'h00, 0, 8'h00, 1,    0,   0,   1,   0,   8'h0C, 1};
        vecs[10] = '{0, 8'h00, 0, 8'h00, 0,    0,   0,   1,   0,   8'h0C, 1};
        vecs[11] = '{0, 8'h00, 1, 8'hFF, 0,    0,   1,   1,   1,   8'hFF, 1};
        vecs[12] = '{1, 8'h01, 1, 8'h02, 0,    0,   0,   0,   1,   8'hFF, 1};
        vecs[13] = '{1, 8'h01, 1, 8'h02, 1,    1,   0,   0,   1,   8'h08, 0};
        vecs[14] = '{1, 8'hFF, 0, 8'h00, 1,    1,   0,   0,   1,   8'hF8, 0};

        do_reset();

        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].v0, vecs[i].d0, vecs[i].v1, vecs[i].d1, vecs[i].ordy);
            #1;
            chk($sformatf("v%0d_in0_ready", i), 32'(in0_ready), 32'(vecs[i].e_rdy0));
            chk($sformatf("v%0d_in1_ready", i), 32'(in1_ready), 32'(vecs[i].e_rdy1));
            chk($sformatf("v%0d_sel", i), 32'(sel), 32'(vecs[i].e_sel));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
            chk($sformatf("v%0d_out_data", i), 32'(out_data), 32'(vecs[i].e_od));
            chk($sformatf("v%0d_out_src", i), 32'(out_src), 32'(vecs[i].e_src));
            @(negedge clk);
        end

        // Fairness from reset: continuous dual requests alternate 0,1,0,1,...
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 8'(i + 1), 1'b1, 8'(8'h40 + i), 1'b1);
            #1;
            chk($sformatf("rr%0d_one_ready", i), 32'(in0_ready ^ in1_ready), 32'd1);
            @(posedge clk);
            #1;
            chk($sformatf("rr%0d_out_src", i), 32'(out_src), 32'(i % 2));
            chk($sformatf("rr%0d_out_data", i), 32'(out_data),
                (i % 2 == 0) ? 32'(8'((i + 1) << 3)) : 32'(8'h40 + i));
            @(negedge clk);
        end

        // Backpressure holds the buffer; release accepts in1 with no bubble.
        do_reset();
        drive(1'b1, 8'h05, 1'b0, 8'h00, 1'b1);
        @(posedge clk);
        #1;
        chk("bp_first_data", 32'(out_data), 32'h28);
        @(negedge clk);
        drive(1'b1, 8'h11, 1'b1, 8'h77, 1'b0);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("bp%0d_readies", i), 32'({in0_ready, in1_ready}), 32'd0);
            @(posedge clk);
            #1;
            chk($sformatf("bp%0d_out_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("bp%0d_out_data", i), 32'(out_data), 32'h28);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_in1_ready", 32'(in1_ready), 32'd1);
        chk("bp_release_in0_ready", 32'(in0_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("bp_release_out_valid", 32'(out_valid), 32'd1);
        chk("bp_release_out_data", 32'(out_data), 32'h77);
        chk("bp_release_out_src", 32'(out_src), 32'd1);

        // Asynchronous reset discards the buffer before any clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_out_data", 32'(out_data), 32'd0);
        chk("arst_out_src", 32'(out_src), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 8'h02, 1'b1, 8'h33, 1'b1);
        #1;
        chk("arst_first_grant_rdy0", 32'(in0_ready), 32'd1);
        chk("arst_first_grant_sel", 32'(sel), 32'd0);
        @(posedge clk);
        #1;
        chk("arst_first_data", 32'(out_data), 32'h10);
        @(negedge clk);
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
